// File: rtl/md_if.sv
// Multiply/divide sequencer bundle between the E stage and md_sequencer.
// The master side is the pipeline; the slave side is the sequencer.
interface md_if;
  logic [3:0]  md_op;
  logic        md_valid;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_is_md;
  logic        start;
  logic        busy;
  logic        md_stall;
  logic [31:0] md_out;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output md_op, md_valid, flush, a, b, d_is_md,
    input  start, busy, md_stall, md_out, hi, lo
  );

  modport slave (
    input  md_op, md_valid, flush, a, b, d_is_md,
    output start, busy, md_stall, md_out, hi, lo
  );
endinterface

// File: rtl/md_sequencer.sv
// E-stage multiply/divide sequencer owning HI/LO.
// Results are computed at accept time and committed after a fixed latency.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic clk,
  input logic reset_n,
  md_if.slave bus
);

  localparam logic [3:0] MC = 4'(MULT_CYCLES);
  localparam logic [3:0] DC = 4'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  cnt;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  logic        is_mul;
  logic        is_div;
  logic        ok;
  logic        start;
  logic        commit;
  logic        dz;
  logic        ovf;

  logic signed [63:0] sa64;
  logic signed [63:0] sb64;
  logic        [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] sa32;
  logic signed [31:0] sd32;
  logic        [31:0] ud32;
  logic        [31:0] q_s;
  logic        [31:0] r_s;
  logic        [31:0] q_u;
  logic        [31:0] r_u;
  logic        [63:0] res;

  // Decode the E-stage op and decide acceptance.
  always_comb begin
    is_mul = (bus.md_op == 4'd1) || (bus.md_op == 4'd2);
    is_div = (bus.md_op == 4'd3) || (bus.md_op == 4'd4);
    ok     = reset_n & bus.md_valid & ~bus.flush & (state == IDLE);
    start  = ok & (is_mul | is_div);
    commit = (state == RUN) && (cnt == 4'd1);
  end

  // Full-width arithmetic; divisors are made safe so the
  // special cases are handled purely by the result mux.
  always_comb begin
    dz     = (bus.b == 32'd0);
    ovf    = (bus.a == 32'h8000_0000) && (bus.b == 32'hFFFF_FFFF);
    sa64   = {{32{bus.a[31]}}, bus.a};
    sb64   = {{32{bus.b[31]}}, bus.b};
    prod_s = sa64 * sb64;
    prod_u = {32'd0, bus.a} * {32'd0, bus.b};
    sa32   = bus.a;
    sd32   = (dz || ovf) ? 32'sd1 : bus.b;
    ud32   = dz ? 32'd1 : bus.b;
    q_s    = sa32 / sd32;
    r_s    = sa32 % sd32;
    q_u    = bus.a / ud32;
    r_u    = bus.a % ud32;
  end

  // Select the {HI,LO} result for the accepted op.
  always_comb begin
    res = '0;
    unique case (1'b1)
      bus.md_op == 4'd1: res = prod_s;
      bus.md_op == 4'd2: res = prod_u;
      bus.md_op == 4'd3: begin
        if (dz)       res = {bus.a, 32'hFFFF_FFFF};
        else if (ovf) res = {32'd0, 32'h8000_0000};
        else          res = {r_s, q_s};
      end
      bus.md_op == 4'd4: begin
        if (dz) res = {bus.a, 32'hFFFF_FFFF};
        else    res = {r_u, q_u};
      end
      default: res = '0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // FSM next state: IDLE->RUN on start, RUN->IDLE on last count.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start)  state_nx = RUN;
      RUN:     if (commit) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Counter, pending result and architectural HI/LO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      res_hi <= '0;
      res_lo <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      if (start) begin
        cnt    <= is_mul ? MC : DC;
        res_hi <= res[63:32];
        res_lo <= res[31:0];
      end else if (state == RUN) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (ok && bus.md_op == 4'd5) begin
        hi_q <= bus.a;
      end else if (ok && bus.md_op == 4'd6) begin
        lo_q <= bus.a;
      end
    end
  end

  // Outputs.
  always_comb begin
    bus.start    = start;
    bus.busy     = (state == RUN);
    bus.md_stall = bus.d_is_md & (start | (state == RUN));
    bus.hi       = hi_q;
    bus.lo       = lo_q;
    bus.md_out   = '0;
    unique case (1'b1)
      bus.md_op == 4'd7: bus.md_out = hi_q;
      bus.md_op == 4'd8: bus.md_out = lo_q;
      default:           bus.md_out = '0;
    endcase
  end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multiply/divide sequencer for the five-stage MIPS pipeline. It sits in the E stage next to the ALU and owns the HI/LO registers. It accepts mult/multu/div/divu from E and models fixed multi-cycle latencies with a down-counter. It also handles mthi/mtlo/mfhi/mflo and produces the D-stage stall for any MD-class instruction (decode `isMD`) that arrives while an operation is pending.

## Interface
- `MULT_CYCLES`, default 5: busy duration for mult/multu; legal range 1..15.
- `DIV_CYCLES`, default 10: busy duration for div/divu; legal range 1..15.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `md_op`  in  4  E-stage opcode:
  - 0 none, 1 mult, 2 multu, 3 div, 4 divu
  - 5 mthi, 6 mtlo, 7 mfhi, 8 mflo
  - 9–15 are treated as none.
- `md_valid`  in  1  E-stage instruction is real (not a bubble).
- `flush`  in  1  exception/interrupt flush of E this cycle; suppresses acceptance.
- `a`  in  32  forwarded rs value.
- `b`  in  32  forwarded rt value.
- `d_is_md`  in  1  D-stage instruction is MD-class.
- `start`  out  1  combinational; an op 1–4 is accepted this cycle.
- `busy`  out  1  registered; an operation is in flight.
- `md_stall`  out  1  combinational; equals `d_is_md & (start | busy)`.
- `md_out`  out  32  combinational; HI for op 7, LO for op 8, else 0.
- `hi`  out  32  architectural HI register.
- `lo`  out  32  architectural LO register.

## Operation
- **Acceptance**
  - `start = md_valid & ~flush & ~busy & (md_op in 1..4)`.
  - On a start edge:
    - `cnt` ← `MULT_CYCLES` (ops 1, 2) or `DIV_CYCLES` (ops 3, 4).
    - The full result is computed from `a`/`b` and captured into `res_hi`/`res_lo`.
    - `busy` ← 1.
- **Counting**
  - While `busy`, `cnt` decrements by 1 per cycle.
  - On the edge where `cnt == 1`: `hi` ← `res_hi`, `lo` ← `res_lo`, `busy` ← 0, `cnt` ← 0.
  - States: IDLE (`busy` = 0) and RUN (`busy` = 1). The only transitions are IDLE→RUN on `start` and RUN→IDLE on `cnt == 1`.
- **Arithmetic**
  - mult: signed 32×32→64; HI = product[63:32], LO = product[31:0].
  - multu: same, unsigned.
  - div: signed, quotient truncated toward zero into LO; remainder into HI, with the sign of the dividend.
  - divu: unsigned.
  - Divide by zero (b = 0): LO = 0xFFFFFFFF, HI = a, for both div and divu.
  - Signed overflow (a = 0x80000000, b = 0xFFFFFFFF): LO = 0x80000000, HI = 0.
- **mthi/mtlo**
  - When `md_valid & ~flush & ~busy`, write `a` to HI/LO on the edge.
  - While `busy`, they are ignored; `md_stall` prevents this case in a correct pipeline.
- **mfhi/mflo**
  - `md_out` reflects current `hi`/`lo` regardless of `busy`; `md_stall` guarantees no stale read.
- **Flush**
  - Blocks `start` and mthi/mtlo in the same cycle.
  - Does NOT cancel an operation already in RUN; it completes and commits.
- **`d_is_md`**
  - Only affects `md_stall`; it has no effect on state.

## Timing
- **Reset** (asynchronous, immediate): `busy` = 0, `cnt` = 0, `hi` = `lo` = 0, `res_hi` = `res_lo` = 0. Combinational outputs follow:
  - `start` = `md_stall` = 0 while `reset_n` is low.
  - `md_out` = 0.
- **Reset mid-operation**: the in-flight result is discarded and HI/LO become 0.
- **Latency** (start accepted in cycle t):
  - `busy` is high in cycles t+1 .. t+N, with N = `MULT_CYCLES` or `DIV_CYCLES`.
  - New `hi`/`lo` are visible from cycle t+N+1.
  - A new start is possible in cycle t+N+1.
- **mthi/mtlo**: the new value is visible on `hi`/`lo`/`md_out` the cycle after the write.
- **Back-to-back**: a mult in t and a mult in t+1 is impossible, because `busy` blocks it. Upstream must hold the instruction in E via `md_stall`.
- **Stall window**: `md_stall` is high in cycle t (`start`) and in t+1 .. t+N whenever `d_is_md` = 1.

## Test plan
- **Signed mult**: mult a = 0xFFFFFFFE (−2), b = 3 → `busy` high for 5 cycles; HI = 0xFFFFFFFF, LO = 0xFFFFFFFA from cycle t+6.
- **Signed div**: div a = −7 (0xFFFFFFF9), b = 2 → after 10 busy cycles, LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. Also divu a = 7, b = 0 → LO = 0xFFFFFFFF, HI = 7.
- **Stall and hazard**: with `d_is_md` = 1 from t through t+12 and multu 0xFFFFFFFF×2 started at t, `md_stall` = 1 for cycles t..t+5 and 0 from t+6. mfhi in t+6 gives `md_out` = 0x00000001, and mflo gives 0xFFFFFFFE.
- **Flush**: mult with `flush` = 1 → `start` = 0, `busy` stays 0, HI/LO unchanged. Flush asserted while in RUN → the operation still commits on schedule.
- **mthi/mtlo**:
  - mthi a = 0x12345678 when idle → `hi` = 0x12345678 next cycle.
  - mtlo presented while `busy` → LO unchanged until the operation's commit value lands.
- **Mid-operation reset**: `reset_n` low at cycle t+3 of a div → `busy`, `hi`, `lo` = 0 immediately. After release, idle state is retained and a new mult completes normally.
